// File: rtl/display_scan_capture_if.sv
// display_scan_capture_if: display pin bus in, captured digit/frame results out.
interface display_scan_capture_if;
    logic [7:0]  an_in;
    logic [7:0]  seg_in;
    logic        cap_strobe;
    logic [2:0]  cap_idx;
    logic [7:0]  cap_seg;
    logic [63:0] frame_seg;
    logic        frame_valid;
    logic        onehot_err;
    modport master (
        output an_in, seg_in,
        input  cap_strobe, cap_idx, cap_seg, frame_seg, frame_valid, onehot_err
    );
    modport slave (
        input  an_in, seg_in,
        output cap_strobe, cap_idx, cap_seg, frame_seg, frame_valid, onehot_err
    );
endinterface

// File: rtl/display_scan_capture.sv
// display_scan_capture: rebuilds 8-digit frames from a multiplexed active-low
// seven-segment bus, capturing each digit once it has been stable long enough.
module display_scan_capture #(
    parameter int SETTLE_CYCLES = 4
) (
    input logic clk,
    input logic rst,
    display_scan_capture_if.slave bus
);
    localparam logic [7:0] SC = 8'(SETTLE_CYCLES);
    typedef enum logic [1:0] {IDLE, SETTLE, HELD, ERR} state_t;
    state_t           state;
    logic [7:0]       an_q, seg_q, an_p, seg_p, cnt, mask, a, mask_nx;
    logic [7:0][7:0]  shadow, shadow_nx;
    logic [3:0]       pop;
    logic [2:0]       idx;
    logic             valid, multi, blank, same, cap, full;
    always_comb begin
        a = ~an_q;
        pop = 4'd0;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) begin
                pop = pop + 4'd1;
                idx = 3'(i);
            end
        end
        blank = pop == 4'd0;
        valid = pop == 4'd1;
        multi = pop > 4'd1;
        same = valid && ({an_q, seg_q} == {an_p, seg_p});
        // a fresh pattern counts as sample 1, so SETTLE_CYCLES=1 captures immediately
        cap = valid && (same ? cnt == SC - 8'd1 : SC == 8'd1);
        mask_nx = mask | (8'h01 << idx);
        full = &mask_nx;
        shadow_nx = shadow;
        shadow_nx[idx] = ~seg_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            an_q            <= 8'hFF;
            seg_q           <= 8'hFF;
            an_p            <= 8'hFF;
            seg_p           <= 8'hFF;
            cnt             <= 8'd0;
            mask            <= 8'd0;
            shadow          <= '0;
            bus.cap_strobe  <= 1'b0;
            bus.cap_idx     <= 3'd0;
            bus.cap_seg     <= 8'd0;
            bus.frame_seg   <= 64'd0;
            bus.frame_valid <= 1'b0;
            bus.onehot_err  <= 1'b0;
        end else begin
            an_q            <= bus.an_in;
            seg_q           <= bus.seg_in;
            an_p            <= an_q;
            seg_p           <= seg_q;
            bus.cap_strobe  <= cap;
            bus.frame_valid <= cap && full;
            bus.onehot_err  <= multi && state != ERR;
            if (blank) begin
                cnt   <= 8'd0;
                state <= IDLE;
            end else if (multi) begin
                cnt   <= 8'd0;
                state <= ERR;
                mask  <= 8'd0;
            end else begin
                cnt   <= !same ? 8'd1 : (cnt < SC ? cnt + 8'd1 : cnt);
                state <= cap ? HELD : (!same ? SETTLE : state);
                if (cap) begin
                    shadow      <= shadow_nx;
                    bus.cap_idx <= idx;
                    bus.cap_seg <= ~seg_q;
                    mask        <= full ? 8'd0 : mask_nx;
                    if (full) bus.frame_seg <= shadow_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_display_scan_capture.sv
// tb_display_scan_capture: scoreboard bench; a small model predicts captures
// and frames as digits are driven, a monitor pops and compares on each pulse.
module tb_display_scan_capture;
    localparam int SC = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    display_scan_capture_if bus ();
    display_scan_capture #(.SETTLE_CYCLES(SC)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, drv_cyc = 0, cap_cyc = 0;
    int n_cap = 0, n_frame = 0, n_err = 0;
    logic [10:0]     cap_q[$];
    logic [63:0]     frame_q[$];
    logic [7:0]      mmask = 8'd0;
    logic [7:0][7:0] mshadow = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    always @(posedge clk) begin
        logic [10:0] e;
        cyc++;
        #1;
        if (bus.cap_strobe) begin
            cap_cyc = cyc;
            n_cap++;
            if (cap_q.size() == 0) chk("cap_unexpected", 64'd1, 64'd0);
            else begin
                e = cap_q.pop_front();
                chk("cap_idx", 64'(bus.cap_idx), 64'(e[10:8]));
                chk("cap_seg", 64'(bus.cap_seg), 64'(e[7:0]));
            end
        end
        if (bus.frame_valid) begin
            n_frame++;
            if (frame_q.size() == 0) chk("frame_unexpected", 64'd1, 64'd0);
            else chk("frame_seg", bus.frame_seg, frame_q.pop_front());
        end
        if (bus.onehot_err) n_err++;
    end

    task automatic drive_raw(input logic [7:0] an, input logic [7:0] seg, input int n);
        @(negedge clk);
        bus.an_in = an;
        bus.seg_in = seg;
        drv_cyc = cyc;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic blank(input int n);
        drive_raw(8'hFF, 8'hFF, n);
    endtask

    task automatic drive(input int i, input logic [7:0] seg, input int n);
        logic [7:0] an;
        an = ~(8'h01 << i);
        if (n >= SC) begin
            mshadow[i] = ~seg;
            cap_q.push_back({3'(i), ~seg});
            mmask = mmask | (8'h01 << i);
            if (&mmask) begin
                frame_q.push_back(mshadow);
                mmask = 8'd0;
            end
        end
        drive_raw(an, seg, n);
    endtask

    task automatic scan(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(i, ~(8'h01 << i), 10);
            blank(2);
        end
    endtask

    initial begin
        int c0, f0, e0;
        bus.an_in = 8'hFF;
        bus.seg_in = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_cap_strobe", 64'(bus.cap_strobe), 64'd0);
        chk("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
        chk("rst_onehot_err", 64'(bus.onehot_err), 64'd0);
        chk("rst_cap_idx", 64'(bus.cap_idx), 64'd0);
        chk("rst_cap_seg", 64'(bus.cap_seg), 64'd0);
        chk("rst_frame_seg", bus.frame_seg, 64'd0);
        blank(20);
        chk("idle_no_caps", 64'(n_cap), 64'd0);

        c0 = n_cap; f0 = n_frame;
        drive(2, 8'hC0, 10);
        chk("single_latency", 64'(cap_cyc - drv_cyc), 64'(SC + 1));
        blank(2);
        chk("single_count", 64'(n_cap - c0), 64'd1);
        chk("single_no_frame", 64'(n_frame - f0), 64'd0);
        chk("single_idx", 64'(bus.cap_idx), 64'd2);
        chk("single_seg", 64'(bus.cap_seg), 64'h3F);

        c0 = n_cap; f0 = n_frame;
        scan(0, 7);
        chk("scan_caps", 64'(n_cap - c0), 64'd8);
        chk("scan_frames", 64'(n_frame - f0), 64'd1);
        chk("scan_frame_seg", bus.frame_seg, 64'h8040201008040201);

        c0 = n_cap;
        drive(3, 8'h00, SC - 1);
        blank(2);
        chk("glitch_no_cap", 64'(n_cap - c0), 64'd0);
        c0 = n_cap;
        drive(5, 8'h92, 2);
        drive(5, 8'h82, 6);
        blank(2);
        chk("restart_one_cap", 64'(n_cap - c0), 64'd1);
        chk("restart_seg", 64'(bus.cap_seg), 64'h7D);

        scan(0, 3);
        e0 = n_err;
        drive_raw(8'hF3, 8'h00, 5);
        mmask = 8'd0;
        blank(2);
        chk("multi_err_once", 64'(n_err - e0), 64'd1);
        f0 = n_frame;
        scan(4, 7);
        chk("multi_aborted", 64'(n_frame - f0), 64'd0);
        scan(0, 7);
        chk("multi_recover", 64'(n_frame - f0), 64'd1);
        chk("multi_frame_seg", bus.frame_seg, 64'h8040201008040201);

        scan(0, 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mmask = 8'd0;
        mshadow = '0;
        f0 = n_frame;
        scan(6, 7);
        chk("rst_mid_no_frame", 64'(n_frame - f0), 64'd0);
        chk("rst_mid_frame_seg", bus.frame_seg, 64'd0);

        blank(5);
        chk("cap_q_drained", 64'(cap_q.size()), 64'd0);
        chk("frame_q_drained", 64'(frame_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
